// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the MEM stage: issues one registered request per
// load/store, stalls the pipeline until the memory answers or the wait budget expires.
module mem_access_ctrl #(
    parameter int unsigned DSIZE   = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_in,
    input  logic             mem_write_in,
    input  logic [DSIZE-1:0] addr_in,
    input  logic [DSIZE-1:0] wdata_in,
    input  logic             dmem_ready,
    input  logic [DSIZE-1:0] dmem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [DSIZE-1:0] dmem_addr,
    output logic [DSIZE-1:0] dmem_wdata,
    output logic             stall,
    output logic [DSIZE-1:0] rdata_out,
    output logic             rdata_valid,
    output logic [1:0]       err,
    output logic [15:0]      acc_count
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    // Counter value on the last allowed ACCESS cycle.
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [DSIZE-1:0] addr_q, addr_d;
    logic [DSIZE-1:0] wdata_q, wdata_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             valid_q, valid_d;
    logic [1:0]       err_q, err_d;
    logic [15:0]      acc_q, acc_d;
    logic             req;
    logic             stall_raw;

    assign req = mem_read_in ^ mem_write_in;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        err_d     = err_q;
        acc_d     = acc_q;
        stall_raw = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (mem_read_in && mem_write_in) begin
                    // Illegal combination: flag it and let the instruction drain.
                    err_d[1] = 1'b1;
                end else if (req) begin
                    stall_raw = 1'b1;
                    we_d      = mem_write_in;
                    addr_d    = addr_in;
                    wdata_d   = wdata_in;
                    cnt_d     = 8'd0;
                    req_d     = 1'b1;
                    state_d   = StAccess;
                end
            end
            StAccess: begin
                stall_raw = 1'b1;
                if (dmem_ready) begin
                    req_d   = 1'b0;
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = dmem_rdata;
                        valid_d = 1'b1;
                    end
                end else if (cnt_q == CntLast) begin
                    err_d[0] = 1'b1;
                    rdata_d  = '0;
                    valid_d  = !we_q;
                    req_d    = 1'b0;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (acc_q != 16'hFFFF) begin
                    acc_d = acc_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            err_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
        end
    end

    assign stall       = stall_raw & rst;
    assign dmem_req    = req_q;
    assign dmem_we     = we_q;
    assign dmem_addr   = addr_q;
    assign dmem_wdata  = wdata_q;
    assign rdata_out   = rdata_q;
    assign rdata_valid = valid_q;
    assign err         = err_q;
    assign acc_count   = acc_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: transaction-level model with a randomized memory responder.
module tb_mem_access_ctrl;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_read_in = 1'b0;
    logic          mem_write_in = 1'b0;
    logic [DW-1:0] addr_in = '0;
    logic [DW-1:0] wdata_in = '0;
    logic          dmem_ready = 1'b0;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic          stall;
    logic [DW-1:0] rdata_out;
    logic          rdata_valid;
    logic [1:0]    err;
    logic [15:0]   acc_count;

    mem_access_ctrl #(
        .DSIZE  (DW),
        .TIMEOUT(TO)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read_in (mem_read_in),
        .mem_write_in(mem_write_in),
        .addr_in     (addr_in),
        .wdata_in    (wdata_in),
        .dmem_ready  (dmem_ready),
        .dmem_rdata  (dmem_rdata),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .err         (err),
        .acc_count   (acc_count)
    );

    always #5 clk = ~clk;

    int       n_cmp = 0;
    int       n_mis = 0;
    logic [1:0] err_exp = 2'b00;
    int       acc_exp = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One instruction held in EXE/MEM until stall drops; memory answers after w wait cycles.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [DW-1:0] a, input logic [DW-1:0] d,
                           input int w, input logic [DW-1:0] rv);
        int         reqc = 0;
        int         stallc = 0;
        int         validc = 0;
        logic [DW-1:0] got = '0;
        logic       bad = 1'b0;
        logic       done = 1'b0;
        logic       illegal;
        logic       is_read;
        logic       to;
        int         nacc;
        illegal = rd & wr;
        is_read = rd & !wr;
        nacc    = (w + 1 < TO) ? w + 1 : TO;
        to      = !illegal && (w + 1 > TO);

        @(negedge clk);
        mem_read_in  = rd;
        mem_write_in = wr;
        addr_in      = a;
        wdata_in     = d;
        for (int c = 0; c < 400 && !done; c++) begin
            #1;
            if (stall) stallc++;
            if (dmem_req) begin
                reqc++;
                if (dmem_we !== wr || dmem_addr !== a || dmem_wdata !== d) bad = 1'b1;
            end
            if (rdata_valid) begin
                validc++;
                got = rdata_out;
            end
            if (dmem_req && reqc == w + 1) begin
                dmem_ready = 1'b1;
                dmem_rdata = rv;
            end else begin
                // Stray ready pulses outside ACCESS must be ignored.
                dmem_ready = dmem_req ? 1'b0 : 1'($urandom_range(0, 1));
                dmem_rdata = $urandom;
            end
            if (!stall) begin
                done = 1'b1;
                @(posedge clk);
                #1;
                mem_read_in  = 1'b0;
                mem_write_in = 1'b0;
                dmem_ready   = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        check_eq({tag, "_bound"}, 64'(done), 64'd1);

        if (illegal) begin
            err_exp[1] = 1'b1;
        end else begin
            if (to) err_exp[0] = 1'b1;
            if (acc_exp < 65535) acc_exp++;
        end
        check_eq({tag, "_stall_cycles"}, 64'(stallc), illegal ? 64'd0 : 64'(nacc + 1));
        check_eq({tag, "_req_cycles"}, 64'(reqc), illegal ? 64'd0 : 64'(nacc));
        check_eq({tag, "_req_stable"}, 64'(bad), 64'd0);
        check_eq({tag, "_valid_cnt"}, 64'(validc), is_read ? 64'd1 : 64'd0);
        if (is_read) check_eq({tag, "_rdata"}, 64'(got), to ? 64'd0 : 64'(rv));
        check_eq({tag, "_err"}, 64'(err), 64'(err_exp));
        check_eq({tag, "_acc"}, 64'(acc_count), 64'(acc_exp));
    endtask

    // Reset asserted during the 3rd ACCESS cycle of a read that never completes.
    task automatic reset_mid_access();
        int   reqc = 0;
        logic bad = 1'b0;
        @(negedge clk);
        mem_read_in = 1'b1;
        addr_in     = 32'h0000_0100;
        dmem_ready  = 1'b0;
        for (int c = 0; c < 50 && reqc < 3; c++) begin
            #1;
            if (dmem_req) reqc++;
            if (reqc < 3) @(negedge clk);
        end
        check_eq("rst_reach_access3", 64'(reqc), 64'd3);
        rst = 1'b0;
        #1;
        check_eq("rst_stall_low", 64'(stall), 64'd0);
        @(posedge clk);
        #1;
        err_exp = 2'b00;
        acc_exp = 0;
        check_eq("rst_req", 64'(dmem_req), 64'd0);
        check_eq("rst_addr", 64'(dmem_addr), 64'd0);
        check_eq("rst_acc", 64'(acc_count), 64'd0);
        check_eq("rst_err", 64'(err), 64'd0);
        check_eq("rst_valid", 64'(rdata_valid), 64'd0);
        mem_read_in = 1'b0;
        rst = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            dmem_ready = 1'($urandom_range(0, 1));
            #1;
            if (dmem_req || rdata_valid || acc_count != 16'd0 || stall) bad = 1'b1;
        end
        dmem_ready = 1'b0;
        check_eq("rst_ready_ignored", 64'(bad), 64'd0);
    endtask

    initial begin
        int sel;
        int w;
        int kind;
        logic rd;
        logic wr;
        // Reset state, with a request pending to show stall is forced low.
        rst = 1'b0;
        mem_read_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_stall", 64'(stall), 64'd0);
        check_eq("reset_req", 64'(dmem_req), 64'd0);
        check_eq("reset_err", 64'(err), 64'd0);
        check_eq("reset_acc", 64'(acc_count), 64'd0);
        check_eq("reset_rdata", 64'(rdata_out), 64'd0);
        check_eq("reset_valid", 64'(rdata_valid), 64'd0);
        mem_read_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_txn("read_0wait", 1'b1, 1'b0, 32'h40, 32'h0, 0, 32'hDEAD_BEEF);
        run_txn("write_4wait", 1'b0, 1'b1, 32'h80, 32'h1234_5678, 4, 32'h0);
        run_txn("read_ready_last", 1'b1, 1'b0, 32'hC0, 32'h0, TO - 1, 32'hCAFE_F00D);
        run_txn("read_timeout", 1'b1, 1'b0, 32'h44, 32'h0, TO, 32'h5555_AAAA);
        run_txn("illegal_rw", 1'b1, 1'b1, 32'h48, 32'h9, 0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            sel  = $urandom_range(0, 7);
            w    = (sel < 5) ? $urandom_range(0, 4) :
                   (sel == 5) ? TO - 1 : (sel == 6) ? TO : $urandom_range(TO, 40);
            kind = $urandom_range(0, 9);
            rd   = (kind == 0) || (kind >= 5);
            wr   = (kind == 0) || (kind < 5);
            run_txn($sformatf("rand%0d", i), rd, wr, $urandom, $urandom, w, $urandom);
        end

        reset_mid_access();
        run_txn("post_rst_read", 1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h0BAD_CAFE);
        run_txn("post_rst_write", 1'b0, 1'b1, 32'h204, 32'h7777_0000, 2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
